// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 1-write / 2-read register file with registered reads,
// per-entry valid bits and a sequential clear engine.
module reg_file_2r1w #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_add,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read_en_a,
    input  logic [ADDR_W-1:0] read_add_a,
    output logic [WIDTH-1:0]  data_out_a,
    output logic              valid_a,
    input  logic              read_en_b,
    input  logic [ADDR_W-1:0] read_add_b,
    output logic [WIDTH-1:0]  data_out_b,
    output logic              valid_b,
    input  logic              clear_req,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [ADDR_W-1:0] ptr;
    logic              do_write;
    logic              do_clear;
    logic              last;
    logic              byp_a;
    logic              byp_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: one clear request walks every entry once
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (clear_req) state_nx = CLEAR;
            CLEAR:   if (last)      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Per-cycle actions decoded from the current state
    always_comb begin
        do_write = (state == IDLE) && write_en;
        do_clear = (state == CLEAR);
        last     = do_clear && (ptr == ADDR_W'(DEPTH - 1));
        byp_a    = do_write && (read_add_a == write_add);
        byp_b    = do_write && (read_add_b == write_add);
    end

    // busy is registered so it mirrors the state without an input path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= 1'b0;
        else        busy <= (state_nx == CLEAR);
    end

    // Clear pointer: parked at 0 in IDLE, walks entries during CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ptr <= '0;
        else if (do_clear)  ptr <= ptr + 1'b1;
        else                ptr <= '0;
    end

    // Storage: clear engine owns the array while active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld <= '0;
        end else if (do_clear) begin
            mem[ptr] <= '0;
            vld[ptr] <= 1'b0;
        end else if (do_write) begin
            mem[write_add] <= data_in;
            vld[write_add] <= 1'b1;
        end
    end

    // Read port A: write-first bypass, zeros while clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_a <= '0;
            valid_a    <= 1'b0;
        end else if (read_en_a) begin
            if (do_clear) begin
                data_out_a <= '0;
                valid_a    <= 1'b0;
            end else if (byp_a) begin
                data_out_a <= data_in;
                valid_a    <= 1'b1;
            end else begin
                data_out_a <= mem[read_add_a];
                valid_a    <= vld[read_add_a];
            end
        end
    end

    // Read port B: same behaviour as port A
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_b <= '0;
            valid_b    <= 1'b0;
        end else if (read_en_b) begin
            if (do_clear) begin
                data_out_b <= '0;
                valid_b    <= 1'b0;
            end else if (byp_b) begin
                data_out_b <= data_in;
                valid_b    <= 1'b1;
            end else begin
                data_out_b <= mem[read_add_b];
                valid_b    <= vld[read_add_b];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scoreboard bench for reg_file_2r1w,
// default (4x4) instance plus an 8-bit, 8-entry instance.
module tb_reg_file_2r1w;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default instance
    logic       we, rea, reb, clr;
    logic [1:0] wa, raa, rab;
    logic [3:0] din, doa, dob;
    logic       va, vb, busy;

    // wide/deep instance
    logic       g_we, g_rea, g_reb, g_clr;
    logic [2:0] g_wa, g_raa, g_rab;
    logic [7:0] g_din, g_doa, g_dob;
    logic       g_va, g_vb, g_busy;

    reg_file_2r1w dut (
        .clk(clk), .rst_n(rst_n),
        .write_en(we), .write_add(wa), .data_in(din),
        .read_en_a(rea), .read_add_a(raa),
        .data_out_a(doa), .valid_a(va),
        .read_en_b(reb), .read_add_b(rab),
        .data_out_b(dob), .valid_b(vb),
        .clear_req(clr), .busy(busy)
    );

    reg_file_2r1w #(.WIDTH(8), .ADDR_W(3)) dut_g (
        .clk(clk), .rst_n(rst_n),
        .write_en(g_we), .write_add(g_wa), .data_in(g_din),
        .read_en_a(g_rea), .read_add_a(g_raa),
        .data_out_a(g_doa), .valid_a(g_va),
        .read_en_b(g_reb), .read_add_b(g_rab),
        .data_out_b(g_dob), .valid_b(g_vb),
        .clear_req(g_clr), .busy(g_busy)
    );

    typedef struct packed {
        logic [3:0] oa;
        logic       va;
        logic [3:0] ob;
        logic       vb;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic [7:0] oa;
        logic       va;
        logic [7:0] ob;
        logic       vb;
    } gexp_t;

    exp_t  sq[$];
    gexp_t gq[$];
    int    checks = 0;
    int    errors = 0;

    // behavioural model of the default instance
    logic [3:0] m_mem [4];
    logic       m_val [4];
    logic [1:0] m_ptr;
    logic       m_busy;
    logic [3:0] m_oa, m_ob;
    logic       m_va, m_vb;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = '0;
            m_val[i] = 1'b0;
        end
        m_ptr = '0; m_busy = 1'b0;
        m_oa = '0; m_ob = '0; m_va = 1'b0; m_vb = 1'b0;
        sq.delete();
    endtask

    task automatic idle_inputs();
        we = 0; wa = 0; din = 0; rea = 0; raa = 0;
        reb = 0; rab = 0; clr = 0;
        g_we = 0; g_wa = 0; g_din = 0; g_rea = 0; g_raa = 0;
        g_reb = 0; g_rab = 0; g_clr = 0;
    endtask

    // push model prediction, clock once, pop and compare
    task automatic tick();
        exp_t e;
        logic [3:0] noa, nob;
        logic nva, nvb;
        noa = m_oa; nob = m_ob; nva = m_va; nvb = m_vb;
        if (!m_busy) begin
            if (rea) begin
                if (we && raa == wa) begin noa = din; nva = 1; end
                else begin noa = m_mem[raa]; nva = m_val[raa]; end
            end
            if (reb) begin
                if (we && rab == wa) begin nob = din; nvb = 1; end
                else begin nob = m_mem[rab]; nvb = m_val[rab]; end
            end
            if (we) begin m_mem[wa] = din; m_val[wa] = 1'b1; end
            if (clr) begin m_busy = 1'b1; m_ptr = '0; end
        end else begin
            if (rea) begin noa = '0; nva = 1'b0; end
            if (reb) begin nob = '0; nvb = 1'b0; end
            m_mem[m_ptr] = '0;
            m_val[m_ptr] = 1'b0;
            if (m_ptr == 2'd3) m_busy = 1'b0;
            m_ptr = m_ptr + 2'd1;
        end
        m_oa = noa; m_ob = nob; m_va = nva; m_vb = nvb;
        sq.push_back('{oa: noa, va: nva, ob: nob, vb: nvb, busy: m_busy});
        @(posedge clk); #1;
        e = sq.pop_front();
        checks++;
        if ({doa, va, dob, vb, busy} !== e) begin
            errors++;
            $display("FAIL model: got oa=%b va=%b ob=%b vb=%b busy=%b exp %b/%b/%b/%b/%b",
                     doa, va, dob, vb, busy, e.oa, e.va, e.ob, e.vb, e.busy);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({doa, va, dob, vb, busy} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got %b%b%b%b%b exp 0",
                     doa, va, dob, vb, busy);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_inputs();
        rea = 1; raa = 2; reb = 1; rab = 0;
        tick();
        idle_inputs();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            we = 1; wa = 2'(i); din = 4'(1 << i);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            rea = 1; raa = 2'(i); reb = 1; rab = 2'(3 - i);
            tick();
            checks++;
            if (doa !== 4'(1 << i) || va !== 1'b1 ||
                dob !== 4'(1 << (3 - i)) || vb !== 1'b1) begin
                errors++;
                $display("FAIL read_%0d: a=%b/%b b=%b/%b exp %b/1 %b/1",
                         i, doa, va, dob, vb, 4'(1 << i), 4'(1 << (3 - i)));
            end
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 1; wa = 2; din = 4'b1111;
        rea = 1; raa = 2; reb = 1; rab = 1;
        tick();
        checks++;
        if (doa !== 4'b1111 || va !== 1'b1 ||
            dob !== 4'b0010 || vb !== 1'b1) begin
            errors++;
            $display("FAIL bypass: a=%b/%b b=%b/%b exp 1111/1 0010/1",
                     doa, va, dob, vb);
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            wa = 2; we = (i == 2); din = 4'b0011;
            tick();
            checks++;
            if (doa !== 4'b1111 || va !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d: a=%b/%b exp 1111/1", i, doa, va);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int n;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            we = 1; wa = 2'(i); din = 4'(4'hA ^ i);
            tick();
        end
        idle_inputs();
        clr = 1;
        tick();
        n = busy ? 1 : 0;
        clr = 0; we = 1; wa = 1; din = 4'b0101;
        rea = 1; raa = 3;
        for (int k = 0; k < 10 && busy; k++) begin
            tick();
            if (busy) n++;
        end
        idle_inputs();
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL clear_len: busy cycles %0d exp 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            rea = 1; raa = 2'(i); reb = 1; rab = 2'(i);
            tick();
            checks++;
            if (doa !== 4'b0 || va !== 1'b0 || dob !== 4'b0 || vb !== 1'b0) begin
                errors++;
                $display("FAIL cleared_%0d: a=%b/%b b=%b/%b exp 0000/0",
                         i, doa, va, dob, vb);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        idle_inputs();
        we = 1; wa = 0; din = 4'b1001;
        tick();
        idle_inputs();
        clr = 1;
        tick();
        clr = 0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_reset: busy=%b exp 0", busy);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_inputs();
        we = 1; wa = 3; din = 4'b0111;
        tick();
        we = 1; wa = 0; din = 4'b1100;
        tick();
        idle_inputs();
        repeat (5) tick();
        rea = 1; raa = 3; reb = 1; rab = 0;
        tick();
        checks++;
        if (doa !== 4'b0111 || va !== 1'b1 ||
            dob !== 4'b1100 || vb !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: a=%b/%b b=%b/%b busy=%b exp 0111/1 1100/1 0",
                     doa, va, dob, vb, busy);
        end
        idle_inputs();
    endtask

    task automatic test_wide();
        gexp_t e;
        int n;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            g_we = 1; g_wa = 3'(i); g_din = 8'(1 << i);
            @(posedge clk); #1;
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            g_rea = 1; g_raa = 3'(i); g_reb = 1; g_rab = 3'(7 - i);
            gq.push_back('{oa: 8'(1 << i), va: 1'b1,
                           ob: 8'(1 << (7 - i)), vb: 1'b1});
            @(posedge clk); #1;
            e = gq.pop_front();
            checks++;
            if ({g_doa, g_va, g_dob, g_vb} !== e) begin
                errors++;
                $display("FAIL wide_read_%0d: a=%h/%b b=%h/%b exp %h/%b %h/%b",
                         i, g_doa, g_va, g_dob, g_vb, e.oa, e.va, e.ob, e.vb);
            end
        end
        idle_inputs();
        g_clr = 1;
        @(posedge clk); #1;
        g_clr = 0;
        n = g_busy ? 1 : 0;
        for (int k = 0; k < 20 && g_busy; k++) begin
            @(posedge clk); #1;
            if (g_busy) n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL wide_clear_len: busy cycles %0d exp 8", n);
        end
        g_rea = 1; g_raa = 7; g_reb = 1; g_rab = 0;
        gq.push_back('{oa: 8'h00, va: 1'b0, ob: 8'h00, vb: 1'b0});
        @(posedge clk); #1;
        e = gq.pop_front();
        checks++;
        if ({g_doa, g_va, g_dob, g_vb} !== e) begin
            errors++;
            $display("FAIL wide_cleared: a=%h/%b b=%h/%b exp 00/0",
                     g_doa, g_va, g_dob, g_vb);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({doa, va, dob, vb, busy} !== 11'd0 ||
            {g_doa, g_va, g_dob, g_vb, g_busy} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got %b %b", {doa, va, dob, vb, busy},
                     {g_doa, g_va, g_dob, g_vb, g_busy});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_write_read();
        test_bypass();
        test_hold();
        test_reset();
        test_clear();
        test_reset_mid_clear();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
